// File: rtl/seq_dp_pkg.sv
// ---------------------------------------------------------------------------
// seq_dp_pkg
// Shared definitions for the sequential datapath:
//   alu_op_e : ALU operation codes carried on alu_op
//   shift_e  : B-operand pre-shift codes carried on shift
//   state_e  : control FSM states (one state per clock, no stalls)
// ---------------------------------------------------------------------------
package seq_dp_pkg;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_SUB  = 2'b01,
    ALU_AND  = 2'b10,
    ALU_NOTB = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4,
    S_DONE = 3'd5
  } state_e;

  localparam int STATUS_W = 3;  // {V,N,Z}

endpackage

// File: rtl/seq_dp_regfile.sv
// ---------------------------------------------------------------------------
// seq_dp_regfile
// NREGS x WIDTH register file, two asynchronous read ports, one synchronous
// write port, cleared by the asynchronous active-low reset.
// Optional build macro SEQ_DATAPATH_DBG_EN adds a third combinational read
// port for debug observation.
// Ports:
//   clk, reset_n          clock / async active-low reset
//   we, waddr, wdata      write port
//   raddr_a / rdata_a     read port A
//   raddr_b / rdata_b     read port B
//   dbg_addr / dbg_data   debug read port (SEQ_DATAPATH_DBG_EN only)
// ---------------------------------------------------------------------------
module seq_dp_regfile
  import seq_dp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
`ifdef SEQ_DATAPATH_DBG_EN
  output logic [WIDTH-1:0] rdata_b,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
`else
  output logic [WIDTH-1:0] rdata_b
`endif
);

  logic [WIDTH-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs <= '{default: '0};
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

`ifdef SEQ_DATAPATH_DBG_EN
  assign dbg_data = regs[dbg_addr];
`endif

endmodule

// File: rtl/seq_datapath.sv
// ---------------------------------------------------------------------------
// seq_datapath
// Multi-cycle register/ALU datapath. An accepted request walks
// IDLE -> RD_A -> RD_B -> EXEC -> WB -> DONE -> IDLE, one state per clock,
// so result_valid pulses exactly 5 clocks after the accepting edge.
// Optional build macro SEQ_DATAPATH_DBG_EN adds dbg_addr/dbg_data.
// Ports:
//   clk, reset_n          clock / async active-low reset
//   req_valid, req_ready  request handshake (ready only in IDLE)
//   alu_op, shift         operation and B pre-shift codes
//   rn, rm, rd            A source, B source, destination register
//   asel, bsel, imm       A:=0 select, B:=imm select, immediate
//   wr_en                 write result to rd (0 = compare only)
//   result_valid          one-cycle pulse; result/status valid
//   result, status        registered result and {V,N,Z}
// ---------------------------------------------------------------------------
module seq_datapath
  import seq_dp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          alu_op,
  input  logic [1:0]          shift,
  input  logic [AW-1:0]       rn,
  input  logic [AW-1:0]       rm,
  input  logic [AW-1:0]       rd,
  input  logic                asel,
  input  logic                bsel,
  input  logic [WIDTH-1:0]    imm,
  input  logic                wr_en,
  output logic                result_valid,
  output logic [WIDTH-1:0]    result,
`ifdef SEQ_DATAPATH_DBG_EN
  output logic [STATUS_W-1:0] status,
  input  logic [AW-1:0]       dbg_addr,
  output logic [WIDTH-1:0]    dbg_data
`else
  output logic [STATUS_W-1:0] status
`endif
);

  function automatic logic signed [WIDTH-1:0] shift_b(
    input logic signed [WIDTH-1:0] b,
    input shift_e                  sh
  );
    case (sh)
      SH_LSL1: return b <<< 1;
      SH_LSR1: return $signed({1'b0, b[WIDTH-1:1]});
      SH_ASR1: return b >>> 1;
      default: return b;
    endcase
  endfunction

  // Returns {V, result}; V is signed overflow for ADD/SUB only.
  function automatic logic [WIDTH:0] alu(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b,
    input alu_op_e                 op
  );
    logic signed [WIDTH-1:0] r;
    logic                    v;
    r = '0;
    v = 1'b0;
    case (op)
      ALU_ADD: begin
        r = a + b;
        v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        r = a - b;
        v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND:  r = a & b;
      default:  r = ~b;
    endcase
    return {v, r};
  endfunction

  state_e                  state_q, state_d;
  alu_op_e                 op_q;
  shift_e                  shift_q;
  logic [AW-1:0]           rn_q, rm_q, rd_q;
  logic                    asel_q, bsel_q, wr_en_q;
  logic [WIDTH-1:0]        imm_q;
  logic signed [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0]        rdata_a, rdata_b;
  logic signed [WIDTH-1:0] b_sh, alu_r;
  logic                    alu_v;
  logic                    accept;

  assign req_ready    = (state_q == S_IDLE);
  assign result_valid = (state_q == S_DONE);
  assign accept       = req_valid && req_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RD_A;
      S_RD_A:  state_d = S_RD_B;
      S_RD_B:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Accept: snapshot the whole request so later input changes are ignored.
  // RD_A / RD_B: latch operands from the register file (pre-write values).
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= alu_op_e'(alu_op);
      shift_q <= shift_e'(shift);
      rn_q    <= rn;
      rm_q    <= rm;
      rd_q    <= rd;
      asel_q  <= asel;
      bsel_q  <= bsel;
      imm_q   <= imm;
      wr_en_q <= wr_en;
    end
    if (state_q == S_RD_A) a_q <= asel_q ? '0 : $signed(rdata_a);
    if (state_q == S_RD_B) b_q <= bsel_q ? $signed(imm_q) : $signed(rdata_b);
  end

  // EXEC: shift B, run the ALU, load result and status.
  assign b_sh           = shift_b(b_q, shift_q);
  assign {alu_v, alu_r} = alu(a_q, b_sh, op_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result <= '0;
      status <= '0;
    end else if (state_q == S_EXEC) begin
      result <= alu_r;
      status <= {alu_v, alu_r[WIDTH-1], (alu_r == '0)};
    end
  end

  // WB: commit the registered result to rd when requested.
  seq_dp_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .we      ((state_q == S_WB) && wr_en_q),
    .waddr   (rd_q),
    .wdata   (result),
    .raddr_a (rn_q),
    .rdata_a (rdata_a),
    .raddr_b (rm_q),
`ifdef SEQ_DATAPATH_DBG_EN
    .rdata_b (rdata_b),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
`else
    .rdata_b (rdata_b)
`endif
  );

endmodule

// File: tb/tb_seq_datapath.sv
// ---------------------------------------------------------------------------
// tb_seq_datapath
// Self-checking bench for seq_datapath (default build, WIDTH=16, NREGS=8).
// Directed vector table, reset-in-EXEC sequence, then randomized operations
// checked against an arithmetic reference model of the register file/ALU.
// ---------------------------------------------------------------------------
module tb_seq_datapath;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int AW = 3;
  localparam longint M = longint'(1) << W;
  localparam longint H = longint'(1) << (W - 1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    alu_op = '0;
  logic [1:0]    shift = '0;
  logic [AW-1:0] rn = '0, rm = '0, rd = '0;
  logic          asel = 1'b0, bsel = 1'b0, wr_en = 1'b0;
  logic [W-1:0]  imm = '0;
  logic          result_valid;
  logic [W-1:0]  result;
  logic [2:0]    status;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint model_rf [N];

  always #5 clk = ~clk;

  seq_datapath #(.WIDTH(W), .NREGS(N)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .alu_op       (alu_op),
    .shift        (shift),
    .rn           (rn),
    .rm           (rm),
    .rd           (rd),
    .asel         (asel),
    .bsel         (bsel),
    .imm          (imm),
    .wr_en        (wr_en),
    .result_valid (result_valid),
    .result       (result),
    .status       (status)
  );

  typedef struct {
    logic [1:0]    op;
    logic [1:0]    sh;
    logic [AW-1:0] rn, rm, rd;
    logic          asel, bsel;
    logic [W-1:0]  imm;
    logic          we;
    longint        res;
    logic [2:0]    st;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint sgn(input longint x);
    return (x >= H) ? x - M : x;
  endfunction

  // Reference: operands from the modelled register file, plain arithmetic.
  task automatic model(input logic [1:0] op, input logic [1:0] sh,
                       input logic [AW-1:0] rn_i, input logic [AW-1:0] rm_i,
                       input logic as, input logic bs, input logic [W-1:0] im,
                       output longint r, output logic [2:0] st);
    longint a, b, s;
    logic   v;
    a = as ? 0 : model_rf[rn_i];
    b = bs ? longint'(im) : model_rf[rm_i];
    case (sh)
      2'd1: b = (b * 2) % M;
      2'd2: b = b / 2;
      2'd3: b = b / 2 + ((b >= H) ? H : 0);
      default: ;
    endcase
    v = 1'b0;
    case (op)
      2'd0: begin s = sgn(a) + sgn(b); r = (a + b) % M;     v = (s > H - 1) || (s < -H); end
      2'd1: begin s = sgn(a) - sgn(b); r = (a + M - b) % M; v = (s > H - 1) || (s < -H); end
      2'd2: r = a & b;
      default: r = M - 1 - b;
    endcase
    st = {v, (r >= H), (r == 0)};
  endtask

  // Issue one request, keep req_valid high with scrambled fields while busy,
  // and check latency, busy-ready, result, status, pulse width and hold.
  task automatic do_op(input logic [1:0] op, input logic [1:0] sh,
                       input logic [AW-1:0] rn_i, input logic [AW-1:0] rm_i,
                       input logic [AW-1:0] rd_i, input logic as, input logic bs,
                       input logic [W-1:0] im, input logic we,
                       input longint exp_r, input logic [2:0] exp_st,
                       input string tag);
    int cyc;
    bit seen;
    @(negedge clk);
    cyc = 0;
    while (!req_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " ready_idle"}, req_ready, 1);
    alu_op = op; shift = sh; rn = rn_i; rm = rm_i; rd = rd_i;
    asel = as; bsel = bs; imm = im; wr_en = we;
    req_valid = 1'b1;
    @(posedge clk);
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      alu_op = 2'($urandom); shift = 2'($urandom);
      rn = AW'($urandom); rm = AW'($urandom); rd = AW'($urandom);
      asel = 1'($urandom); bsel = 1'($urandom);
      imm = W'($urandom); wr_en = 1'($urandom);
      if (result_valid) seen = 1;
      else check({tag, " ready_busy"}, req_ready, 0);
    end
    req_valid = 1'b0;
    check({tag, " valid_seen"}, seen, 1);
    check({tag, " latency"}, cyc, 5);
    check({tag, " ready_done"}, req_ready, 0);
    check({tag, " result"}, result, exp_r);
    check({tag, " status"}, status, exp_st);
    @(negedge clk);
    check({tag, " pulse_width"}, result_valid, 0);
    check({tag, " result_hold"}, result, exp_r);
    if (we) model_rf[rd_i] = exp_r;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint     er;
    logic [2:0] es;
    int         pulses;
    logic [W-1:0] pick [5];

    //                op    sh    rn    rm    rd    as    bs    imm       we    res      st
    tbl[0]  = '{2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 16'h0007, 1'b1, 'h0007, 3'b000};
    tbl[1]  = '{2'd0, 2'd0, 3'd0, 3'd0, 3'd1, 1'b1, 1'b1, 16'h0002, 1'b1, 'h0002, 3'b000};
    tbl[2]  = '{2'd0, 2'd1, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 16'h0000, 1'b1, 'h000B, 3'b000};
    tbl[3]  = '{2'd0, 2'd0, 3'd0, 3'd0, 3'd3, 1'b1, 1'b1, 16'h7FFF, 1'b1, 'h7FFF, 3'b000};
    tbl[4]  = '{2'd0, 2'd0, 3'd0, 3'd0, 3'd4, 1'b1, 1'b1, 16'h0001, 1'b1, 'h0001, 3'b000};
    tbl[5]  = '{2'd0, 2'd0, 3'd3, 3'd4, 3'd5, 1'b0, 1'b0, 16'h0000, 1'b1, 'h8000, 3'b110};
    tbl[6]  = '{2'd1, 2'd0, 3'd4, 3'd4, 3'd6, 1'b0, 1'b0, 16'h0000, 1'b0, 'h0000, 3'b001};
    tbl[7]  = '{2'd0, 2'd0, 3'd0, 3'd6, 3'd7, 1'b1, 1'b0, 16'h0000, 1'b0, 'h0000, 3'b001};
    tbl[8]  = '{2'd0, 2'd3, 3'd0, 3'd0, 3'd7, 1'b1, 1'b1, 16'h8000, 1'b0, 'hC000, 3'b010};
    tbl[9]  = '{2'd0, 2'd2, 3'd0, 3'd0, 3'd7, 1'b1, 1'b1, 16'h8000, 1'b0, 'h4000, 3'b000};
    tbl[10] = '{2'd2, 2'd0, 3'd5, 3'd0, 3'd7, 1'b0, 1'b1, 16'hFFFF, 1'b0, 'h8000, 3'b010};
    tbl[11] = '{2'd3, 2'd0, 3'd0, 3'd0, 3'd7, 1'b0, 1'b1, 16'h00FF, 1'b0, 'hFF00, 3'b010};
    tbl[12] = '{2'd0, 2'd0, 3'd0, 3'd2, 3'd7, 1'b1, 1'b0, 16'h0000, 1'b0, 'h000B, 3'b000};
    tbl[13] = '{2'd1, 2'd0, 3'd0, 3'd3, 3'd7, 1'b0, 1'b0, 16'h0000, 1'b0, 'h8008, 3'b010};
    tbl[14] = '{2'd1, 2'd0, 3'd5, 3'd4, 3'd7, 1'b0, 1'b0, 16'h0000, 1'b0, 'h7FFF, 3'b100};

    for (int i = 0; i < N; i++) model_rf[i] = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset ready", req_ready, 1);
    check("reset valid", result_valid, 0);
    check("reset result", result, 0);
    check("reset status", status, 0);
    reset_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 15; i++) begin
      do_op(tbl[i].op, tbl[i].sh, tbl[i].rn, tbl[i].rm, tbl[i].rd,
            tbl[i].asel, tbl[i].bsel, tbl[i].imm, tbl[i].we,
            tbl[i].res, tbl[i].st, $sformatf("vec%0d", i));
    end

    // Reset pulsed during EXEC: no pulse, no writeback, everything cleared
    @(negedge clk);
    alu_op = 2'd0; shift = 2'd0; rn = 3'd0; rm = 3'd0; rd = 3'd3;
    asel = 1'b1; bsel = 1'b1; imm = 16'h1234; wr_en = 1'b1;
    req_valid = 1'b1;
    @(posedge clk);
    req_valid = 1'b0;
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (result_valid) pulses++;
    end
    reset_n = 1'b0;
    #1;
    check("rst_exec ready_async", req_ready, 1);
    check("rst_exec valid", result_valid, 0);
    check("rst_exec result", result, 0);
    check("rst_exec status", status, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (result_valid) pulses++;
    end
    check("rst_exec no_pulse", pulses, 0);
    check("rst_exec ready_after", req_ready, 1);
    for (int i = 0; i < N; i++) model_rf[i] = 0;
    do_op(2'd0, 2'd0, 3'd0, 3'd3, 3'd0, 1'b1, 1'b0, 16'h0, 1'b0, 0, 3'b001, "rst_exec rd_cleared");
    do_op(2'd0, 2'd0, 3'd0, 3'd1, 3'd0, 1'b1, 1'b0, 16'h0, 1'b0, 0, 3'b001, "rst_exec r1_cleared");

    // Randomized operations against the reference model
    pick[0] = 16'h0000; pick[1] = 16'h7FFF; pick[2] = 16'h8000; pick[3] = 16'hFFFF;
    for (int k = 0; k < 40; k++) begin
      logic [1:0]    op_r, sh_r;
      logic [AW-1:0] rn_r, rm_r, rd_r;
      logic          as_r, bs_r, we_r;
      logic [W-1:0]  im_r;
      op_r = 2'($urandom); sh_r = 2'($urandom);
      rn_r = AW'($urandom); rm_r = AW'($urandom); rd_r = AW'($urandom);
      as_r = ($urandom_range(0, 3) == 0);
      bs_r = 1'($urandom);
      we_r = ($urandom_range(0, 3) != 0);
      pick[4] = W'($urandom);
      im_r = pick[$urandom_range(0, 4)];
      model(op_r, sh_r, rn_r, rm_r, as_r, bs_r, im_r, er, es);
      do_op(op_r, sh_r, rn_r, rm_r, rd_r, as_r, bs_r, im_r, we_r, er, es,
            $sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_datapath.md
SEQ_DATAPATH -- requirements
Module: seq_datapath

Interface
REQ-001 Parameter WIDTH, default 16, datapath and register width in bits (>=4).
REQ-002 Parameter NREGS, default 8, register count (power of two, >=2); AW = log2(NREGS).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  operation request present.
REQ-006 req_ready  out  1  block idle and able to accept a request.
REQ-007 alu_op  in  2  00 ADD, 01 SUB (A-B), 10 AND, 11 NOT B.
REQ-008 shift  in  2  applied to B: 00 none, 01 LSL1, 10 LSR1 zero-fill, 11 ASR1.
REQ-009 rn, rm, rd  in  AW each  A source, B source, destination register.
REQ-010 asel  in  1  1 forces A operand to zero.
REQ-011 bsel  in  1  1 selects imm instead of Rm as B before shifting.
REQ-012 imm  in  WIDTH  immediate operand.
REQ-013 wr_en  in  1  1 writes result to Rd; 0 is compare-only.
REQ-014 result_valid  out  1  one-cycle pulse, result and status valid.
REQ-015 result  out  WIDTH  registered ALU result.
REQ-016 status  out  3  registered {V,N,Z}.

Function
REQ-017 FSM states IDLE, RD_A, RD_B, EXEC, WB, DONE; one state per cycle, no stalls after acceptance.
REQ-018 Accept when req_valid && req_ready; all request fields captured that edge; later input changes ignored until the next acceptance.
REQ-019 req_ready high only in IDLE; requests arriving in any other state are ignored, not queued.
REQ-020 RD_A latches A (Rn, or zero if asel); RD_B latches B (imm if bsel, else Rm).
REQ-021 EXEC computes shift(B), then alu_op, modulo 2^WIDTH; loads result and status.
REQ-022 Z = result==0; N = result[WIDTH-1]; V = signed overflow for ADD/SUB, 0 for AND/NOT.
REQ-023 WB writes result to Rd iff wr_en; register file otherwise unchanged.
REQ-024 DONE asserts result_valid for exactly one cycle, then returns to IDLE; accept-to-result_valid latency fixed at 5 cycles.
REQ-025 Back-to-back ops: the next op, accepted in the cycle after DONE, observes the prior write (no hazard path).
REQ-026 rn==rm, rd==rn or rd==rm permitted; reads use pre-write values of the current op.
REQ-027 result and status hold their values between operations.

Reset
REQ-028 reset_n low: state IDLE, all registers, result, status 0, result_valid 0; req_ready rises immediately.
REQ-029 Reset mid-operation aborts it: no writeback, no result_valid pulse.

Configuration
REQ-030 Macro SEQ_DATAPATH_DBG_EN defined: add ports dbg_addr (in, AW) and dbg_data (out, WIDTH), combinational read of register dbg_addr.
REQ-031 Macro undefined: debug ports absent; no other behaviour change.

Structure
REQ-032 Package seq_dp_pkg holds ALU op codes, shift codes, FSM state enum.
REQ-033 Register file is sub-module seq_dp_regfile (NREGS x WIDTH, two read ports, one write port, async reset clear).

Verification
REQ-034 imm=7, bsel=1, asel=1, ADD, rd=0, wr_en=1 -> result 7, status 000, R0=7, result_valid 5 cycles after accept.
REQ-035 R0=7, imm=2 -> R1; ADD rn=0, rm=1, shift LSL1, rd=2 -> R2=11 (0x000B).
REQ-036 R3=0x7FFF, R4=1, ADD rd=5 -> 0x8000, status V=1 N=1 Z=0; SUB R4-R4 wr_en=0 -> Z=1, R-file unchanged.
REQ-037 imm=0x8000, bsel, asel, ASR1 -> 0xC000; LSR1 -> 0x4000.
REQ-038 req_valid held during busy cycles -> req_ready 0, exactly one op executed per acceptance.
REQ-039 reset_n pulsed low in EXEC -> no result_valid, Rd unchanged (0), req_ready 1 after release.
